// File: rtl/alu_sequencer.sv
// Program sequencer for the 8-bit accumulator CPU: replays a small instruction
// memory into the CPU control inputs on a fixed 2-cycle-per-instruction schedule.
module alu_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [16:0]   prog_wdata,
  input  logic          start,
  input  logic          abort,
  input  logic          cpu_cout,
  output logic [7:0]    cpu_data_in,
  output logic [6:0]    cpu_opcode,
  output logic          cpu_cin,
  output logic          cpu_load,
  output logic          cpu_ce,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic          last_cout,
  output logic          prog_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_DONE
  } state_t;

  logic [16:0]   r_mem [DEPTH];
  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [7:0]    r_cnt;
  logic [7:0]    r_data;
  logic [6:0]    r_opcode;
  logic          r_cin;
  logic          r_load;
  logic          r_ce;
  logic          r_ce_d;
  logic          r_busy;
  logic          r_done;
  logic          r_last_cout;
  logic          r_prog_err;

  state_t        w_state_nxt;
  logic [AW-1:0] w_pc_nxt;
  logic [7:0]    w_cnt_nxt;
  logic [16:0]   w_word;
  logic          w_is_cpu;
  logic          w_is_halt;
  logic          w_is_wait;
  logic          w_at_end;
  logic          w_issue;
  logic          w_advance;
  logic          w_start_ok;

  // abort beats a coincident start even when abort itself has nothing to stop
  assign w_start_ok = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_word      = r_mem[r_pc];
    w_is_cpu    = w_word[16] || (w_word[11:8] <= 4'hA);
    w_is_halt   = !w_word[16] && (w_word[11:8] == 4'hF);
    w_is_wait   = !w_word[16] && (w_word[11:8] == 4'hE) && (w_word[7:0] != '0);
    w_at_end    = (r_pc == AW'(DEPTH - 1));
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_issue     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = '0;
        end
      end
      S_FETCH: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_is_cpu) begin
          w_state_nxt = S_EXEC;
          w_issue     = 1'b1;
        end else if (w_is_halt) begin
          w_state_nxt = S_DONE;
        end else if (w_is_wait) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = w_word[7:0];
        end else begin
          w_advance = 1'b1;
        end
      end
      S_EXEC: begin
        if (abort) w_state_nxt = S_IDLE;
        else       w_advance   = 1'b1;
      end
      S_WAIT: begin
        if (abort)              w_state_nxt = S_IDLE;
        else if (r_cnt == 8'd1) w_advance   = 1'b1;
        else                    w_cnt_nxt   = r_cnt - 8'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_advance) begin
      if (w_at_end) begin
        w_state_nxt = S_DONE;
      end else begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = r_pc + AW'(1);
      end
    end
  end

  // CPU-facing fields are registered on the FETCH->EXEC edge so they are valid during EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_cnt       <= '0;
      r_data      <= '0;
      r_opcode    <= '0;
      r_cin       <= 1'b0;
      r_load      <= 1'b0;
      r_ce        <= 1'b0;
      r_ce_d      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_last_cout <= 1'b0;
      r_prog_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ce    <= w_issue;
      r_load  <= w_issue && w_word[16];
      if (w_issue) begin
        r_opcode <= w_word[14:8];
        r_data   <= w_word[7:0];
        r_cin    <= w_word[15];
      end
      r_busy <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_EXEC) || (w_state_nxt == S_WAIT);
      r_done <= (w_state_nxt == S_DONE);
      r_ce_d <= r_ce;
      if (r_ce_d) r_last_cout <= cpu_cout;
      if (prog_we && r_busy) r_prog_err <= 1'b1;
      else if (w_start_ok)   r_prog_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we && !r_busy) r_mem[prog_addr] <= prog_wdata;
  end

  assign cpu_data_in = r_data;
  assign cpu_opcode  = r_opcode;
  assign cpu_cin     = r_cin;
  assign cpu_load    = r_load;
  assign cpu_ce      = r_ce;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pc          = r_pc;
  assign last_cout   = r_last_cout;
  assign prog_err    = r_prog_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: constant vector table plus an instruction-level
// timeline model replayed cycle by cycle against the design.
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [16:0] prog_wdata;
  logic        start;
  logic        abort;
  logic        cpu_cout;
  logic [7:0]  cpu_data_in;
  logic [6:0]  cpu_opcode;
  logic        cpu_cin;
  logic        cpu_load;
  logic        cpu_ce;
  logic        busy;
  logic        done;
  logic [3:0]  pc;
  logic        last_cout;
  logic        prog_err;

  alu_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .abort(abort), .cpu_cout(cpu_cout),
    .cpu_data_in(cpu_data_in), .cpu_opcode(cpu_opcode), .cpu_cin(cpu_cin),
    .cpu_load(cpu_load), .cpu_ce(cpu_ce), .busy(busy), .done(done), .pc(pc),
    .last_cout(last_cout), .prog_err(prog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ce;
    logic       load;
    logic [6:0] op;
    logic [7:0] data;
    logic       cin;
    logic       busy;
    logic       done;
    logic [3:0] pc;
    logic       perr;
  } obs_t;

  typedef struct {
    logic [16:0] word;
    int          done_at;
    int          n_ce;
    logic [6:0]  op;
    logic [7:0]  data;
    logic        cin;
    logic        load;
  } vec_t;

  localparam logic [16:0] HALT = {1'b0, 1'b0, 7'h0F, 8'h00};

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  logic [16:0] pm [16];
  obs_t        q[$];
  int          ce_at[$];
  logic [6:0]  m_op;
  logic [7:0]  m_data;
  logic        m_cin;
  logic [3:0]  m_pc;
  logic        m_done;
  logic        m_perr;
  logic        lc_exp;
  logic        prev_ce;

  function automatic obs_t sample();
    obs_t a;
    a.ce = cpu_ce; a.load = cpu_load; a.op = cpu_opcode; a.data = cpu_data_in;
    a.cin = cpu_cin; a.busy = busy; a.done = done; a.pc = pc; a.perr = prog_err;
    return a;
  endfunction

  function automatic obs_t quiet();
    obs_t r;
    r.ce = 1'b0; r.load = 1'b0; r.op = m_op; r.data = m_data; r.cin = m_cin;
    r.busy = 1'b0; r.done = m_done; r.pc = m_pc; r.perr = m_perr;
    return r;
  endfunction

  // one clock: clear pulses, compare against the expected record, then drive cout
  task automatic cyc(input obs_t e);
    obs_t a;
    @(negedge clk);
    cyc_n++;
    start = 1'b0; abort = 1'b0; prog_we = 1'b0; rst = 1'b0;
    a = sample();
    if (a.ce === 1'b1) ce_at.push_back(cyc_n);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL outputs cyc=%0d got ce=%b ld=%b op=%h d=%h cin=%b busy=%b done=%b pc=%0d perr=%b exp ce=%b ld=%b op=%h d=%h cin=%b busy=%b done=%b pc=%0d perr=%b",
               cyc_n, a.ce, a.load, a.op, a.data, a.cin, a.busy, a.done, a.pc, a.perr,
               e.ce, e.load, e.op, e.data, e.cin, e.busy, e.done, e.pc, e.perr);
    end
    checks++;
    if (last_cout !== lc_exp) begin
      failures++;
      $display("FAIL last_cout cyc=%0d got %b exp %b", cyc_n, last_cout, lc_exp);
    end
    cpu_cout = 1'($urandom_range(0, 1));
    if (prev_ce) lc_exp = cpu_cout;
    prev_ce = e.ce;
  endtask

  task automatic do_reset();
    obs_t a;
    @(negedge clk);
    rst = 1'b1; start = 1'b0; abort = 1'b0; prog_we = 1'b0; cpu_cout = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    a = sample();
    checks++;
    if (a !== '0 || last_cout !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got %h last_cout=%b exp 0", a, last_cout);
    end
    m_op = '0; m_data = '0; m_cin = 1'b0; m_pc = '0; m_done = 1'b0; m_perr = 1'b0;
    lc_exp = 1'b0; prev_ce = 1'b0;
  endtask

  task automatic write_word(input int a, input logic [16:0] d);
    cyc(quiet());
    prog_we = 1'b1; prog_addr = 4'(a); prog_wdata = d;
    pm[a] = d;
  endtask

  task automatic flush_pm();
    for (int i = 0; i < 16; i++) write_word(i, pm[i]);
  endtask

  // instruction-level interpretation of pm into the expected per-cycle timeline
  task automatic build();
    obs_t r;
    int   p;
    bit   fin;
    logic [16:0] w;
    q.delete();
    p = 0; fin = 1'b0;
    r = quiet();
    r.perr = 1'b0;
    while (!fin) begin
      w = pm[p];
      r.pc = 4'(p); r.busy = 1'b1; r.done = 1'b0; r.ce = 1'b0; r.load = 1'b0;
      q.push_back(r);
      if (w[16] || w[11:8] <= 4'hA) begin
        r.ce = 1'b1; r.load = w[16]; r.op = w[14:8]; r.data = w[7:0]; r.cin = w[15];
        q.push_back(r);
        r.ce = 1'b0; r.load = 1'b0;
      end else if (w[11:8] == 4'hF) begin
        fin = 1'b1;
      end else if (w[11:8] == 4'hE) begin
        for (int k = 0; k < int'(w[7:0]); k++) q.push_back(r);
      end
      if (!fin) begin
        if (p == 15) fin = 1'b1;
        else p++;
      end
    end
    r.busy = 1'b0; r.done = 1'b1;
    q.push_back(r);
  endtask

  // cut_kind: 0 run to DONE, 1 abort at cycle cut_at, 2 rst at cycle cut_at
  task automatic run(input int cut_at, input int cut_kind, input int we_at, input int start_at);
    obs_t e;
    int   n;
    int   cut;
    bit   perr_set;
    cyc(quiet());
    start = 1'b1;
    build();
    cut = cut_at;
    if (cut > q.size() - 1) cut = q.size() - 1;
    n = (cut_kind == 0) ? q.size() : cut;
    perr_set = 1'b0;
    for (int c = 1; c <= n; c++) begin
      e = q[c-1];
      if (perr_set) e.perr = 1'b1;
      cyc(e);
      if (c == we_at && c < q.size()) begin
        prog_we = 1'b1; prog_addr = 4'd3; prog_wdata = ~pm[3];
        perr_set = 1'b1;
      end
      if (c == start_at && c < q.size()) start = 1'b1;
      if (cut_kind == 1 && c == cut) abort = 1'b1;
      if (cut_kind == 2 && c == cut) begin
        rst = 1'b1; lc_exp = 1'b0; prev_ce = 1'b0;
      end
    end
    e = q[n-1];
    m_op = e.op; m_data = e.data; m_cin = e.cin; m_pc = e.pc;
    m_done = (cut_kind == 0); m_perr = perr_set;
    if (cut_kind == 2) begin
      m_op = '0; m_data = '0; m_cin = 1'b0; m_pc = '0; m_done = 1'b0; m_perr = 1'b0;
    end
    cyc(quiet());
    cyc(quiet());
  endtask

  function automatic logic [16:0] rand_word();
    logic [16:0] w;
    int unsigned k;
    k = $urandom_range(0, 9);
    w = 17'($urandom);
    if (k <= 5) begin
      if (!w[16] && w[11:8] > 4'hA) w[11:8] = 4'($urandom_range(0, 10));
    end else if (k <= 7) begin
      w[16] = 1'b0; w[11:8] = 4'hE; w[7:0] = 8'($urandom_range(0, 4));
    end else if (k == 8) begin
      w[16] = 1'b0; w[11:8] = 4'($urandom_range(11, 13));
    end else begin
      w[16] = 1'b0; w[11:8] = 4'hF;
    end
    return w;
  endfunction

  vec_t tv[9];
  logic [7:0] init_imm [8];

  initial begin
    int got_done;
    int nce;
    logic [6:0] g_op;
    logic [7:0] g_data;
    logic g_cin;
    logic g_load;

    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    start = 1'b0; abort = 1'b0; cpu_cout = 1'b0;
    lc_exp = 1'b0; prev_ce = 1'b0;

    tv[0] = '{{1'b1, 1'b0, 7'h71, 8'h05}, 4, 1, 7'h71, 8'h05, 1'b0, 1'b1};
    tv[1] = '{{1'b0, 1'b1, 7'h0A, 8'h33}, 4, 1, 7'h0A, 8'h33, 1'b1, 1'b0};
    tv[2] = '{{1'b0, 1'b0, 7'h0E, 8'h03}, 6, 0, 7'h00, 8'h00, 1'b0, 1'b0};
    tv[3] = '{{1'b0, 1'b0, 7'h0E, 8'h00}, 3, 0, 7'h00, 8'h00, 1'b0, 1'b0};
    tv[4] = '{{1'b0, 1'b0, 7'h3B, 8'h07}, 3, 0, 7'h00, 8'h00, 1'b0, 1'b0};
    tv[5] = '{{1'b0, 1'b0, 7'h0D, 8'hFF}, 3, 0, 7'h00, 8'h00, 1'b0, 1'b0};
    tv[6] = '{{1'b0, 1'b0, 7'h0F, 8'h00}, 2, 0, 7'h00, 8'h00, 1'b0, 1'b0};
    tv[7] = '{{1'b0, 1'b0, 7'h0E, 8'h01}, 4, 0, 7'h00, 8'h00, 1'b0, 1'b0};
    tv[8] = '{{1'b1, 1'b0, 7'h0F, 8'h10}, 4, 1, 7'h0F, 8'h10, 1'b0, 1'b1};

    do_reset();

    // single instruction followed by HALT: latency to done and issued fields
    for (int v = 0; v < 9; v++) begin
      @(negedge clk); prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = tv[v].word;
      @(negedge clk); prog_addr = 4'd1; prog_wdata = HALT;
      @(negedge clk); prog_we = 1'b0; start = 1'b1;
      pm[0] = tv[v].word; pm[1] = HALT;
      got_done = 0; nce = 0;
      g_op = '0; g_data = '0; g_cin = 1'b0; g_load = 1'b0;
      for (int c = 1; c <= 40 && got_done == 0; c++) begin
        @(negedge clk); start = 1'b0;
        if (cpu_ce) begin
          nce++; g_op = cpu_opcode; g_data = cpu_data_in; g_cin = cpu_cin; g_load = cpu_load;
        end
        if (done) got_done = c;
      end
      checks++;
      if (got_done != tv[v].done_at) begin
        failures++;
        $display("FAIL vec%0d done_cycle got %0d exp %0d", v, got_done, tv[v].done_at);
      end
      checks++;
      if (nce != tv[v].n_ce) begin
        failures++;
        $display("FAIL vec%0d ce_count got %0d exp %0d", v, nce, tv[v].n_ce);
      end
      if (tv[v].n_ce == 1) begin
        checks++;
        if ({g_op, g_data, g_cin, g_load} !== {tv[v].op, tv[v].data, tv[v].cin, tv[v].load}) begin
          failures++;
          $display("FAIL vec%0d issue got op=%h d=%h cin=%b ld=%b exp op=%h d=%h cin=%b ld=%b",
                   v, g_op, g_data, g_cin, g_load, tv[v].op, tv[v].data, tv[v].cin, tv[v].load);
        end
      end
    end

    do_reset();

    // register init program
    init_imm = '{8'h01, 8'h02, 8'hAA, 8'h0F, 8'h05, 8'h04, 8'h40, 8'h80};
    for (int i = 0; i < 8; i++) pm[i] = {1'b1, 1'b0, 3'(i), 4'h0, init_imm[i]};
    pm[8] = HALT;
    for (int i = 9; i < 16; i++) pm[i] = {1'b1, 1'b1, 7'h55, 8'(i)};
    flush_pm();
    run(0, 0, 0, 0);

    // ALU program
    pm[0] = {1'b0, 1'b1, 7'h10, 8'h00};
    pm[1] = {1'b0, 1'b0, 7'h02, 8'h00};
    pm[2] = HALT;
    flush_pm();
    run(0, 0, 0, 0);

    // NOP gap between two EXECs
    pm[0] = {1'b0, 1'b0, 7'h13, 8'h11};
    pm[1] = {1'b0, 1'b0, 7'h0E, 8'd3};
    pm[2] = {1'b0, 1'b0, 7'h24, 8'h22};
    pm[3] = HALT;
    flush_pm();
    ce_at.delete();
    run(0, 0, 0, 0);
    checks++;
    if (ce_at.size() != 2 || ce_at[1] - ce_at[0] != 6) begin
      failures++;
      $display("FAIL nop_spacing got %0d pulses gap %0d exp 2 pulses gap 6",
               ce_at.size(), (ce_at.size() >= 2) ? ce_at[1] - ce_at[0] : -1);
    end

    // no HALT: runs to the last word and stops without wrapping
    for (int i = 0; i < 16; i++) pm[i] = {1'b0, i[0], 3'(i), 4'(i % 11), 8'(i * 7)};
    flush_pm();
    ce_at.delete();
    run(0, 0, 0, 0);
    checks++;
    if (ce_at.size() != 16) begin
      failures++;
      $display("FAIL nohalt_pulses got %0d exp 16", ce_at.size());
    end

    // abort at third EXEC (with a coincident start), then restart from 0
    run(6, 1, 0, 6);
    run(0, 0, 0, 0);

    // start and abort together while not busy: nothing happens
    cyc(quiet());
    start = 1'b1; abort = 1'b1;
    cyc(quiet());
    cyc(quiet());

    // program write while busy is dropped, extra start ignored; rerun proves memory intact
    run(0, 0, 5, 9);
    run(0, 0, 0, 0);

    // rst during EXEC after a dropped write
    run(4, 2, 3, 0);
    run(0, 0, 0, 0);

    // randomized programs, some aborted mid-run
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 16; i++) pm[i] = rand_word();
      flush_pm();
      if ($urandom_range(0, 3) == 0) run($urandom_range(1, 20), 1, 0, 0);
      else run(0, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Program sequencer for the 8-bit accumulator CPU: holds a small instruction memory and replays it into the CPU's data_in/opcode/cin/load/ce inputs.
- Replaces hand-timed stimulus and future host pokes with a deterministic 2-cycle-per-instruction schedule.
- Sits between the host/program loader and the CPU; it is the sole driver of the CPU control inputs.

Parameters:
- DEPTH, 16, number of instruction words; power of two.
- AW, 4, program address width; log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  write strobe for the instruction memory.
- prog_addr  in  AW  write address.
- prog_wdata  in  17  instruction word: [16]=load, [15]=cin, [14:8]=opcode {reg[2:0],op[3:0]}, [7:0]=imm.
- start  in  1  pulse; begins execution at address 0.
- abort  in  1  pulse; stops execution.
- cpu_cout  in  1  carry out from CPU.
- cpu_data_in  out  8  to CPU data_in.
- cpu_opcode  out  7  to CPU opcode.
- cpu_cin  out  1  to CPU cin.
- cpu_load  out  1  to CPU load.
- cpu_ce  out  1  to CPU ce.
- busy  out  1  high in FETCH/EXEC/WAIT.
- done  out  1  high in DONE.
- pc  out  AW  address of the current instruction.
- last_cout  out  1  cpu_cout sampled on the cycle after each EXEC.
- prog_err  out  1  sticky; set on a prog_we while busy.

Behaviour:
- Reset: state=IDLE, pc=0, all cpu_* outputs=0, busy=done=last_cout=prog_err=0. Memory contents are not reset.
- Memory write: accepted only when busy=0; one word per cycle. A prog_we with busy=1 is dropped and sets prog_err. prog_err clears only on rst or on start.
- Instruction classes:
  - load=1 or op in 0x0..0xA: CPU instruction.
  - load=0, op=0xE: NOP, wait imm cycles.
  - load=0, op=0xF: HALT.
  - load=0, op in 0xB..0xD: treated as NOP with imm=0.
- State machine:
  - IDLE: start -> FETCH, pc=0. A start in DONE behaves the same way.
  - FETCH: registered memory read of mem[pc]; cpu_ce=0; 1 cycle.
    - CPU instruction -> EXEC.
    - NOP, imm>0 -> WAIT with counter=imm.
    - NOP, imm=0 -> advance.
    - HALT -> DONE.
  - EXEC: exactly 1 cycle. cpu_ce=1; cpu_load, cpu_cin, cpu_opcode, cpu_data_in come from the word. Then advance.
  - WAIT: cpu_ce=0; counter decrements each cycle; at counter=1 -> advance. NOP imm=N therefore occupies 1+N cycles.
  - advance: if pc=DEPTH-1 -> DONE (no wrap); else pc+1 -> FETCH.
  - DONE: done=1, busy=0, outputs idle; stay until start.
- Outside EXEC, cpu_ce=0 and cpu_load=0. cpu_opcode, cpu_data_in and cpu_cin hold their last EXEC values (CPU sees stable inputs; ce gates them).
- Timing: a CPU instruction at pc=k issued in cycle t is followed by next-instruction EXEC at t+2. First EXEC occurs 2 cycles after the start cycle.
- last_cout: updated in the cycle following every EXEC; otherwise holds.
- abort: in any busy state -> IDLE next cycle. pc holds; cpu_ce=0 and cpu_load=0 immediately (registered next edge); done stays 0. Ignored when not busy.
- Simultaneous events:
  - abort and start in the same cycle: abort wins.
  - start while busy: ignored.
  - rst overrides everything, including mid-EXEC; the CPU never sees ce=1 on the cycle after rst is asserted.
- All outputs are registered.

Test Plan:
- Register init program: 8 words load=1, reg 0..7, imm {01,02,AA,0F,05,04,40,80}, then HALT. start -> cpu_ce/cpu_load pulse at cycles 2,4,…,16 after start with the matching opcode/imm; done=1 at cycle 18; busy=0.
- ALU program: ADD REG0, cin=1, then LSHIFT ACCU, then HALT, with ACCU=01 and REG0=02 -> cpu_opcode 0x10 with cin=1, then 0x02 with cin=0; CPU data_out 8'h04 then 8'h08; last_cout=0.
- NOP timing: word0 ADD, word1 NOP imm=3, word2 SUB -> EXECs 6 cycles apart (2+4); cpu_ce=0 throughout the gap.
- No HALT: all 16 words are CPU instructions -> 16 EXEC pulses, pc stops at 15, done=1, pc does not wrap to 0.
- abort at the 3rd EXEC cycle -> the next cycle has cpu_ce=0, busy=0, done=0, pc=2. A subsequent start restarts at pc=0.
- prog_we while busy -> memory unchanged (readback via rerun); prog_err=1. rst during EXEC -> all outputs 0 on the next edge; prog_err=0.
